tile_feeder: RTL and testbench
==============================

// Module: tile_feeder
// PURPOSE
// - Upstream stage of the row shifter: generates the periodic one-cycle shift strobe and the 2-bit lane code
//   of the new top-row tile (random) that the shifter loads into line_0 on that strobe.
// - Owns game pacing: idle/run/halt FSM, period counter, progressive speed-up, 16-bit LFSR, repeat limiting.
// PARAMETERS
// - SEED           16'hACE1      LFSR reset value; also reload value on all-zero lock-up
// - START_PERIOD   12_500_000    clk cycles between shifts at game start (PERIOD_W bits)
// - MIN_PERIOD     3_000_000     floor for the shift period
// - STEP           250_000       period decrement per speed-up
// - SPEEDUP_EVERY  8             shifts between speed-ups (>=1)
// - MAX_REPEAT     2             max consecutive tiles in the same lane (>=1)
// - PERIOD_W       24            width of period/counter registers
// PORTS
// - clk          in   1         system clock
// - resetn       in   1         asynchronous, active-low reset
// - start        in   1         pulse: IDLE/HALT -> RUN
// - enable       in   1         pause when low (RUN only)
// - game_over    in   1         level/pulse: RUN -> HALT
// - shift        out  1         one-cycle strobe to shifter
// - random       out  2         lane of new tile; valid and stable from shift cycle until next shift
// - tile_present out  1         new row carries a tile (see CONFIGURATION)
// - period       out  PERIOD_W  current shift period
// - running      out  1         high in RUN
// BEHAVIOUR
// - Reset: state=IDLE, lfsr=SEED, period=START_PERIOD, cnt=0, shift=0, random=0, tile_present=1,
//   running=0, repeat_cnt=0, spd_cnt=0.
// - LFSR: Galois, poly x^16+x^14+x^13+x^11 (mask 16'hB400), advances every cycle in all states;
//   if value reaches 0, next value is SEED.
// - FSM: IDLE --start--> RUN; RUN --game_over--> HALT; HALT --start--> RUN. Start while in RUN is ignored.
//   start and game_over in the same cycle: game_over wins (RUN->HALT; IDLE/HALT stay).
// - On entry to RUN: period=START_PERIOD, cnt=START_PERIOD-1, spd_cnt=0, repeat_cnt=0. LFSR is not reseeded.
// - RUN, enable=1: cnt decrements; when cnt==0, on the next edge shift=1 for exactly one cycle, random and
//   tile_present update on that edge, cnt reloads period-1.
//   The first shift is START_PERIOD cycles after the start edge.
// - RUN, enable=0: cnt frozen, shift=0; resumes with no lost/extra shift.
// - Lane select: cand=lfsr[1:0]. If cand==random and repeat_cnt==MAX_REPEAT-1, output (cand+1) mod 4 and
//   repeat_cnt=0; else if cand==random repeat_cnt++; else repeat_cnt=0.
// - Speed-up: spd_cnt counts shifts; at SPEEDUP_EVERY, spd_cnt=0 and period=max(period-STEP, MIN_PERIOD)
//   (saturating, no wrap). The new period takes effect at the next reload.
// - HALT/IDLE: shift=0; random, tile_present, period hold last values; running=0.
// - Reset mid-game: immediate return to reset values; any strobe in flight is dropped.
// CONFIGURATION
// - TILE_FEEDER_BLANK_EN defined: on each shift, if lfsr[3:2]==2'b00 and the previous row had a tile,
//   tile_present=0 (blank row; random holds previous value, repeat_cnt unchanged).
//   Two blank rows in a row are never produced.
// - Undefined: tile_present constant 1; no blank-row logic synthesised.
// TESTING (bench params: START_PERIOD=4, MIN_PERIOD=2, STEP=1, SPEEDUP_EVERY=3, MAX_REPEAT=2, PERIOD_W=4)
// - Reset, then start pulse -> running=1; shift pulses 4 cycles after the start edge, then every 4 cycles;
//   each pulse is 1 cycle wide.
// - 3 shifts -> period=3 and the gap to the next shift is 3; after 6 shifts period=2; after 9+ shifts it
//   stays 2 (saturation).
// - Force a repeated lane (SEED chosen so cand repeats) -> never 3 equal consecutive random values;
//   third becomes (lane+1)%4.
// - enable low for 10 cycles mid-count -> no shift during the pause; remaining count honoured after resume.
// - game_over and start asserted in the same cycle in RUN -> HALT, shift stays 0;
//   later start -> RUN, period=4.
// - resetn low mid-RUN -> all outputs at reset values asynchronously; with TILE_FEEDER_BLANK_EN,
//   1000 shifts show no two consecutive tile_present=0.

Source files
------------

// File: rtl/tile_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tile_feeder
// Purpose  : Pacing stage ahead of the row shifter. Produces a one-cycle shift
//            strobe every `period` enabled cycles while running, together with
//            the lane code of the tile that enters the top row on that strobe.
//            The period shrinks by STEP every SPEEDUP_EVERY shifts, down to
//            MIN_PERIOD. Lanes come from a free-running 16-bit Galois LFSR,
//            and no lane is repeated more than MAX_REPEAT times in a row.
// Ports    : clk          - system clock
//            resetn       - asynchronous active-low reset
//            start        - IDLE/HALT -> RUN (ignored while running)
//            enable       - pauses the period count when low
//            game_over    - RUN -> HALT (has priority over start)
//            shift        - one-cycle strobe to the shifter
//            random       - lane of the new tile, held between strobes
//            tile_present - new row carries a tile
//            period       - current shift period in clk cycles
//            running      - high while in RUN
// Options  : TILE_FEEDER_BLANK_EN - when defined, a shift may emit a blank
//            row (tile_present=0) if lfsr[3:2]==0 and the previous row had
//            a tile. When undefined, tile_present is tied to 1.
// Revision : 1.0 - initial release
// ============================================================================
module tile_feeder #(
    parameter int          PERIOD_W      = 24,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          START_PERIOD  = 12_500_000,
    parameter int          MIN_PERIOD    = 3_000_000,
    parameter int          STEP          = 250_000,
    parameter int          SPEEDUP_EVERY = 8,
    parameter int          MAX_REPEAT    = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                enable,
    input  logic                game_over,
    output logic                shift,
    output logic [1:0]          random,
    output logic                tile_present,
    output logic [PERIOD_W-1:0] period,
    output logic                running
);

    localparam logic [15:0]         c_LFSR_MASK = 16'hB400;
    localparam int                  c_REP_W     = (MAX_REPEAT > 1) ? $clog2(MAX_REPEAT) : 1;
    localparam int                  c_SPD_W     = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
    localparam logic [PERIOD_W-1:0] c_START     = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] c_START_M1  = PERIOD_W'(START_PERIOD - 1);
    localparam logic [PERIOD_W-1:0] c_MIN       = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] c_STEP      = PERIOD_W'(STEP);
    // Smallest period that can still take a full STEP without crossing the floor.
    localparam logic [PERIOD_W:0]   c_SAT_AT    = (PERIOD_W+1)'(MIN_PERIOD + STEP);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(MAX_REPEAT - 1);
    localparam logic [c_SPD_W-1:0]  c_SPD_LAST  = c_SPD_W'(SPEEDUP_EVERY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                r_state;
    logic [15:0]           r_lfsr;
    logic [PERIOD_W-1:0]   r_period;
    logic [PERIOD_W-1:0]   r_cnt;
    logic                  r_shift;
    logic [1:0]            r_random;
    logic [c_REP_W-1:0]    r_rep;
    logic [c_SPD_W-1:0]    r_spd;

    state_t                w_state_next;
    logic                  w_enter_run;
    logic                  w_tick;
    logic                  w_fire;
    logic [15:0]           w_lfsr_next;
    logic [1:0]            w_cand;
    logic [1:0]            w_lane;
    logic [c_REP_W-1:0]    w_rep_next;
    logic [c_SPD_W-1:0]    w_spd_next;
    logic [PERIOD_W-1:0]   w_period_dec;
    logic [PERIOD_W-1:0]   w_period_next;
    logic                  w_blank;

`ifdef TILE_FEEDER_BLANK_EN
    logic                  r_tile;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and per-cycle decisions
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_enter_run   = 1'b0;
        w_lane        = 2'd0;
        w_rep_next    = '0;
        w_blank       = 1'b0;

        case (r_state)
            S_IDLE, S_HALT: begin
                // game_over in the same cycle keeps us out of RUN.
                if (start && !game_over) begin
                    w_state_next = S_RUN;
                    w_enter_run  = 1'b1;
                end
            end
            S_RUN: begin
                if (game_over) begin
                    w_state_next = S_HALT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_tick = (r_state == S_RUN) && !game_over && enable;
        w_fire = w_tick && (r_cnt == '0);

        // Galois step; all-zero can only arise from an upset, reload the seed.
        if (r_lfsr == '0) begin
            w_lfsr_next = SEED;
        end else begin
            w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
        end

        // Repeat limiting: the candidate is bumped to the next lane once the
        // current lane has already appeared MAX_REPEAT times in a row.
        w_cand = r_lfsr[1:0];
        if ((w_cand == r_random) && (r_rep == c_REP_LAST)) begin
            w_lane     = w_cand + 2'd1;
            w_rep_next = '0;
        end else if (w_cand == r_random) begin
            w_lane     = w_cand;
            w_rep_next = r_rep + c_REP_W'(1);
        end else begin
            w_lane     = w_cand;
            w_rep_next = '0;
        end

        // Speed-up; the reload on the same strobe already uses the new period.
        w_period_dec  = ({1'b0, r_period} >= c_SAT_AT) ? (r_period - c_STEP) : c_MIN;
        w_spd_next    = (r_spd == c_SPD_LAST) ? '0 : (r_spd + c_SPD_W'(1));
        w_period_next = (r_spd == c_SPD_LAST) ? w_period_dec : r_period;

`ifdef TILE_FEEDER_BLANK_EN
        // Never two blank rows back to back.
        w_blank = (r_lfsr[3:2] == 2'b00) && r_tile;
`endif
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr   <= SEED;
            r_period <= c_START;
            r_cnt    <= '0;
            r_shift  <= 1'b0;
            r_random <= 2'd0;
            r_rep    <= '0;
            r_spd    <= '0;
`ifdef TILE_FEEDER_BLANK_EN
            r_tile   <= 1'b1;
`endif
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_shift <= w_fire;
            if (w_enter_run) begin
                r_period <= c_START;
                r_cnt    <= c_START_M1;
                r_spd    <= '0;
                r_rep    <= '0;
            end else if (w_fire) begin
                r_cnt    <= w_period_next - PERIOD_W'(1);
                r_period <= w_period_next;
                r_spd    <= w_spd_next;
                // A blank row keeps the previous lane and repeat history.
                if (!w_blank) begin
                    r_random <= w_lane;
                    r_rep    <= w_rep_next;
                end
`ifdef TILE_FEEDER_BLANK_EN
                r_tile   <= !w_blank;
`endif
            end else if (w_tick) begin
                r_cnt <= r_cnt - PERIOD_W'(1);
            end
        end
    end

    assign shift   = r_shift;
    assign random  = r_random;
    assign period  = r_period;
    assign running = (r_state == S_RUN);
`ifdef TILE_FEEDER_BLANK_EN
    assign tile_present = r_tile;
`else
    assign tile_present = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tile_feeder
// Purpose  : Self-checking bench for tile_feeder. A reference model counts
//            enabled cycles per gap and derives lanes/periods from the game
//            rules; expected strobes are queued and a monitor compares them
//            against the DUT outputs on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_feeder;

    localparam int          START = 4;
    localparam int          MINP  = 2;
    localparam int          STEPV = 1;
    localparam int          SPD   = 3;
    localparam int          MAXR  = 2;
    localparam int          PW    = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef TILE_FEEDER_BLANK_EN
    localparam bit          BLANK = 1'b1;
`else
    localparam bit          BLANK = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic          start     = 1'b0;
    logic          enable    = 1'b0;
    logic          game_over = 1'b0;
    logic          shift;
    logic [1:0]    random;
    logic          tile_present;
    logic [PW-1:0] period;
    logic          running;

    tile_feeder #(
        .PERIOD_W      (PW),
        .SEED          (SEED),
        .START_PERIOD  (START),
        .MIN_PERIOD    (MINP),
        .STEP          (STEPV),
        .SPEEDUP_EVERY (SPD),
        .MAX_REPEAT    (MAXR)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .enable       (enable),
        .game_over    (game_over),
        .shift        (shift),
        .random       (random),
        .tile_present (tile_present),
        .period       (period),
        .running      (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] lane;
        logic       tile;
        int         per;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'h0000) return SEED;
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: state 0=idle 1=run 2=halt
    // ------------------------------------------------------------------------
    logic [15:0] m_lfsr;
    logic [15:0] m_cur;
    logic [1:0]  m_cand;
    logic [1:0]  m_rand;
    logic        m_tile;
    int          m_state, m_period, m_elapsed, m_shifts, m_run;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_lfsr    = SEED;
            m_state   = 0;
            m_period  = START;
            m_elapsed = 0;
            m_shifts  = 0;
            m_run     = 1;
            m_rand    = 2'd0;
            m_tile    = 1'b1;
            q.delete();
        end else begin
            cyc++;
            m_cur  = m_lfsr;
            m_lfsr = lfsr_step(m_cur);
            if (m_state == 1) begin
                if (game_over) begin
                    m_state = 2;
                end else if (enable) begin
                    m_elapsed++;
                    if (m_elapsed == m_period) begin
                        m_elapsed = 0;
                        m_cand    = m_cur[1:0];
                        if (BLANK && m_cur[3:2] == 2'b00 && m_tile) begin
                            m_tile = 1'b0;
                        end else begin
                            m_tile = 1'b1;
                            if (m_cand == m_rand) begin
                                if (m_run == MAXR) begin
                                    m_rand = m_cand + 2'd1;
                                    m_run  = 1;
                                end else begin
                                    m_run++;
                                end
                            end else begin
                                m_rand = m_cand;
                                m_run  = 1;
                            end
                        end
                        m_shifts++;
                        if (m_shifts % SPD == 0)
                            m_period = (m_period - STEPV < MINP) ? MINP : m_period - STEPV;
                        q.push_back('{cyc, m_rand, m_tile, m_period});
                    end
                end
            end else if (start && !game_over) begin
                m_state   = 1;
                m_period  = START;
                m_elapsed = 0;
                m_shifts  = 0;
                m_run     = 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    logic       prev_shift   = 1'b0;
    logic       prev_running = 1'b0;
    logic       prev_tile    = 1'b1;
    logic [1:0] last_lane    = 2'd0;
    int         eq_run       = 1;
    int         n_shifts     = 0;
    int         n_blank      = 0;

    always @(negedge clk) begin
        exp_t e;
        int   exp_shift;
        if (resetn) begin
            if (running && !prev_running) begin
                eq_run    = 1;
                last_lane = random;
            end
            exp_shift = (q.size() > 0 && q[0].cyc == cyc) ? 1 : 0;
            chk("shift", int'(shift), exp_shift);
            if (exp_shift == 1) begin
                e = q.pop_front();
                chk("lane", int'(random), int'(e.lane));
                chk("tile_present", int'(tile_present), int'(e.tile));
                chk("period_after_shift", int'(period), e.per);
            end
            if (shift) begin
                n_shifts++;
                chk("pulse_width", int'(prev_shift), 0);
                if (tile_present) begin
                    eq_run    = (random == last_lane) ? eq_run + 1 : 1;
                    last_lane = random;
                    chk("repeat_limit_ok", int'(eq_run <= MAXR), 1);
                end else begin
                    n_blank++;
                end
`ifdef TILE_FEEDER_BLANK_EN
                chk("no_double_blank", int'(tile_present || prev_tile), 1);
`endif
                prev_tile = tile_present;
            end
            chk("running", int'(running), int'(m_state == 1));
            chk("random_hold", int'(random), int'(m_rand));
            chk("period", int'(period), m_period);
            prev_shift   = shift;
            prev_running = running;
        end else begin
            prev_shift   = 1'b0;
            prev_running = 1'b0;
            prev_tile    = 1'b1;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_shift"},   int'(shift), 0);
        chk({tag, "_random"},  int'(random), 0);
        chk({tag, "_tile"},    int'(tile_present), 1);
        chk({tag, "_period"},  int'(period), START);
        chk({tag, "_running"}, int'(running), 0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int halt_shifts;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        #2 resetn = 1'b1;

        // Start and run with enable high: 4-cycle gaps, then speed-up to saturation.
        @(negedge clk) start = 1'b1;
        @(negedge clk) begin
            start  = 1'b0;
            enable = 1'b1;
        end
        chk("running_after_start", int'(running), 1);
        repeat (45) @(negedge clk);

        // Pause mid-count.
        repeat (1) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);

        // Random enable pattern.
        repeat (300) begin
            @(negedge clk);
            enable = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // game_over and start together while running.
        @(negedge clk) begin
            game_over = 1'b1;
            start     = 1'b1;
        end
        @(negedge clk) begin
            game_over = 1'b0;
            start     = 1'b0;
        end
        halt_shifts = 0;
        repeat (20) begin
            @(negedge clk);
            if (shift) halt_shifts++;
        end
        chk("halt_no_shift", halt_shifts, 0);
        chk("halt_running", int'(running), 0);

        // Restart from HALT: period back to START.
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart_period", int'(period), START);
        chk("restart_running", int'(running), 1);

        // Long randomized game.
        repeat (4000) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 7) != 0);
            game_over = ($urandom_range(0, 999) == 0);
            start     = ($urandom_range(0, 99) == 0);
        end
        game_over = 1'b0;
        start     = 1'b1;
        enable    = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);

        // Asynchronous reset mid-run.
        #2 resetn = 1'b0;
        #1 check_reset_vals("async_reset");
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (30) @(negedge clk);

        chk("shifts_seen", int'(n_shifts > 100), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
